// File: rtl/apb1_pkg.sv
// rtl/apb1_pkg.sv - shared state encodings, defaults and APB field widths
package apb1_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = 4;
    localparam int unsigned APB_PW = 3;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [3:0] S_IDLE   = 4'b0001;
    localparam logic [3:0] S_SETUP  = 4'b0010;
    localparam logic [3:0] S_ACCESS = 4'b0100;
    localparam logic [3:0] S_ERR    = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE   = S_IDLE,
        ST_SETUP  = S_SETUP,
        ST_ACCESS = S_ACCESS,
        ST_ERR    = S_ERR
    } apb1_state_e;

endpackage

// File: rtl/apb1_rr_arb2.sv
// rtl/apb1_rr_arb2.sv - combinational two-way round-robin picker
module apb1_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    // last_grant_i = 1 means m1 was served last, so m0 wins a tie
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/apb1_root_arbiter.sv
// rtl/apb1_root_arbiter.sv - shares one APB root bus between two requesters with a pready watchdog
module apb1_root_arbiter
    import apb1_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              i_hclk,
    input  logic              i_hrst,
    input  logic              i_pclk_en,
    input  logic              i_m0_psel,
    input  logic              i_m0_penable,
    input  logic [APB_AW-1:0] i_m0_paddr,
    input  logic              i_m0_pwrite,
    input  logic [APB_DW-1:0] i_m0_pwdata,
    input  logic [APB_SW-1:0] i_m0_pstrb,
    input  logic [APB_PW-1:0] i_m0_pprot,
    output logic              o_m0_pready,
    output logic              o_m0_pslverr,
    output logic [APB_DW-1:0] o_m0_prdata,
    input  logic              i_m1_psel,
    input  logic              i_m1_penable,
    input  logic [APB_AW-1:0] i_m1_paddr,
    input  logic              i_m1_pwrite,
    input  logic [APB_DW-1:0] i_m1_pwdata,
    input  logic [APB_SW-1:0] i_m1_pstrb,
    input  logic [APB_PW-1:0] i_m1_pprot,
    output logic              o_m1_pready,
    output logic              o_m1_pslverr,
    output logic [APB_DW-1:0] o_m1_prdata,
    input  logic              i_root_pready,
    input  logic              i_root_pslverr,
    input  logic [APB_DW-1:0] i_root_prdata,
    output logic              o_root_psel,
    output logic              o_root_penable,
    output logic              o_root_pwrite,
    output logic [APB_AW-1:0] o_root_paddr,
    output logic [APB_DW-1:0] o_root_pwdata,
    output logic [APB_SW-1:0] o_root_pstrb,
    output logic [APB_PW-1:0] o_root_pprot,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    apb1_state_e       state_q;
    logic [1:0]        grant_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [APB_AW-1:0] paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [APB_SW-1:0] pstrb_q;
    logic [APB_PW-1:0] pprot_q;

    logic [1:0]        win_d;
    logic              unused_penable;

    // requester penable carries no sequencing information here
    assign unused_penable = i_m0_penable ^ i_m1_penable;

    apb1_rr_arb2 u_arb (
        .req_i        ({i_m1_psel, i_m0_psel}),
        .last_grant_i (last_q),
        .grant_o      (win_d)
    );

    always_ff @(posedge i_hclk) begin
        timeout_q <= 1'b0;
        if (i_hrst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else if (i_pclk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_d != 2'b00) begin
                        grant_q  <= win_d;
                        psel_q   <= 1'b1;
                        pwrite_q <= win_d[1] ? i_m1_pwrite : i_m0_pwrite;
                        paddr_q  <= win_d[1] ? i_m1_paddr  : i_m0_paddr;
                        pwdata_q <= win_d[1] ? i_m1_pwdata : i_m0_pwdata;
                        pstrb_q  <= win_d[1] ? i_m1_pstrb  : i_m0_pstrb;
                        pprot_q  <= win_d[1] ? i_m1_pprot  : i_m0_pprot;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (i_root_pready) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        grant_q   <= 2'b00;
                        last_q    <= grant_q[1];
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else if (WD_EN && cnt_q == TO_LAST) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_ERR;
                    end else if (WD_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    grant_q <= 2'b00;
                    last_q  <= grant_q[1];
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic in_access;
    logic in_err;
    logic done_ok;

    assign in_access = (state_q == ST_ACCESS);
    assign in_err    = (state_q == ST_ERR);
    assign done_ok   = in_access & i_root_pready;

    assign o_m0_pready  = grant_q[0] & (done_ok | in_err);
    assign o_m1_pready  = grant_q[1] & (done_ok | in_err);
    assign o_m0_pslverr = grant_q[0] & ((done_ok & i_root_pslverr) | in_err);
    assign o_m1_pslverr = grant_q[1] & ((done_ok & i_root_pslverr) | in_err);
    assign o_m0_prdata  = (grant_q[0] & in_access) ? i_root_prdata : '0;
    assign o_m1_prdata  = (grant_q[1] & in_access) ? i_root_prdata : '0;

    assign o_root_psel    = psel_q;
    assign o_root_penable = penable_q;
    assign o_root_pwrite  = pwrite_q;
    assign o_root_paddr   = paddr_q;
    assign o_root_pwdata  = pwdata_q;
    assign o_root_pstrb   = pstrb_q;
    assign o_root_pprot   = pprot_q;
    assign o_grant        = grant_q;
    assign o_timeout      = timeout_q;

endmodule
